cla_accumulator: RTL
====================

# cla_accumulator

Streaming 32-bit accumulator that sits directly downstream of the carry look-ahead adder chain. Each accepted operand is added into a running sum by a ripple of 4-bit CLA slices. The block tracks unsigned carry-out and signed overflow. On the last beat of a packet it presents the packet total on a valid/ready output port, then clears itself for the next packet.

## Interface
- `WIDTH`, default 32: operand and sum width; must be a multiple of 4, one 4-bit CLA slice per nibble.
- `CNT_W`, default 8: width of the beat counter.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: block can accept a beat.
- `in_data`  in  WIDTH: operand to add.
- `in_last`  in  1: qualifies the final beat of a packet.
- `clr`  in  1: abort the current packet and zero the accumulator.
- `out_valid`  out  1: packet result valid.
- `out_ready`  in  1: consumer takes the result.
- `out_sum`  out  WIDTH: packet total, modulo 2^WIDTH.
- `out_carry`  out  1: sticky; some addition in the packet produced carry-out of the MSB slice.
- `out_ovf`  out  1: sticky; some addition in the packet produced two's-complement overflow.
- `out_count`  out  CNT_W: number of beats accepted in the packet; saturates at 2^CNT_W−1.

## Operation
- The block has two states, ACC and HOLD.
- **ACC state**
  - `in_ready`=1, `out_valid`=0.
  - A beat is accepted when `in_valid & in_ready`.
  - On an accepted beat: next acc = acc + `in_data`, computed with cin=0 through the CLA slice chain.
  - carry |= cout of the MSB slice.
  - ovf |= (acc[MSB]==`in_data`[MSB]) & (sum[MSB]!=acc[MSB]).
  - count increments, saturating.
- **Entering HOLD:** a beat accepted with `in_last`=1 updates the registers as above and moves the block to HOLD.
- **HOLD state**
  - `in_ready`=0, `out_valid`=1.
  - `out_sum`/`out_carry`/`out_ovf`/`out_count` show the registered final values and are held stable.
  - `in_valid` and `clr` are ignored.
  - On `out_ready`=1: the block returns to ACC, and acc, carry, ovf and count all clear to 0 in that same edge.
- **`clr` in ACC**
  - Without a beat: acc, carry, ovf and count go to 0.
  - With a simultaneous accepted beat: `clr` wins over the old contents, and the beat starts a fresh packet. acc=`in_data`, carry=0, ovf=0, count=1.
  - If that beat also has `in_last`=1, the block enters HOLD with that single-beat result.
- **Outputs in ACC:** `out_sum`, `out_carry`, `out_ovf` and `out_count` show the live running registers. They are meaningful only while `out_valid`=1.
- **Arithmetic:** the sum is computed unsigned modulo 2^WIDTH. The carry and overflow flags are sticky per packet, never per beat.
- **Empty packet:** none can occur; every packet contains at least one beat, namely the `in_last` beat.

## Timing
- **Reset:** `rst` is sampled on `clk`. The cycle after `rst`=1 gives state=ACC, acc=0, carry=0, ovf=0, count=0, `in_ready`=1, `out_valid`=0.
- Reset mid-packet or during HOLD discards all state, including an unconsumed result.
- **Throughput:** one beat per cycle in ACC; the adder path is single-cycle combinational into the registers.
- **Latency:** `out_valid` rises on the edge that accepts the `in_last` beat, i.e. visible the cycle after that beat.
- **Minimum packet cycle:** last beat, then one HOLD cycle with `out_ready`=1. The next beat can be accepted in the cycle after the handshake. There is no combinational path from `out_ready` to `in_ready`.
- **Backpressure:** while `out_valid` & !`out_ready`, all outputs are held stable indefinitely.
- **`in_ready`:** depends only on state, never combinationally on `in_valid`.

## Test plan
- **Reset:** hold `rst` 2 cycles → `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, flags 0. Assert `rst` again mid-packet after beat 0x5 → `out_sum`=0, `out_count`=0 next cycle.
- **Basic sum:** beats 0x0000000A, 0x0000000C, 0x00000005(last), back-to-back → `out_valid` next cycle; `out_sum`=0x0000001B, `out_count`=3, `out_carry`=0, `out_ovf`=0.
- **Unsigned wrap:** beats 0xFFFFFFFF, 0x00000002(last) → `out_sum`=0x00000001, `out_carry`=1, `out_ovf`=0.
- **Signed overflow, sticky:** beats 0x7FFFFFFF, 0x00000001, 0xFFFFFFFF(last) → `out_sum`=0x7FFFFFFF, `out_ovf`=1, `out_carry`=1, `out_count`=3.
- **Backpressure:** after the result, hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 with 0x9.
  - Required during the stall: outputs stable, `in_ready`=0, no beat accepted.
  - Then assert `out_ready` and send 0x4(last) → `out_sum`=0x4, `out_count`=1.
- **`clr`:**
  - Beats 0x10, 0x20, then a beat 0x3 with `clr`=1 → acc=0x3, count=1, flags 0.
  - Then 0x1(last) → `out_sum`=0x4, `out_count`=2.
  - `clr` asserted during HOLD → result unchanged.

Source files
------------

// File: rtl/cla_accumulator.sv
// Streaming packet accumulator built on a ripple of 4-bit CLA slices.
// Tracks sticky carry/overflow and beat count; presents each packet total on a valid/ready port.
module cla_accumulator #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   localparam int unsigned NSLICE = WIDTH / 4;
   localparam int unsigned MSB    = WIDTH - 1;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t             state_q, state_nxt;
   logic [WIDTH-1:0]   acc_q, acc_nxt;
   logic               carry_q, carry_nxt;
   logic               ovf_q, ovf_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic               rdy_q;
   logic               vld_q;

   logic               beat;
   logic [WIDTH-1:0]   add_a;
   logic [WIDTH-1:0]   add_sum;
   logic [NSLICE:0]    add_c;
   logic [4:0]         slice;
   logic               carry_base;
   logic               ovf_base;
   logic [CNT_W-1:0]   cnt_base;

   // One 4-bit carry look-ahead slice: returns {cout, sum[3:0]}
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      return {c[4], p ^ c[3:0]};
   endfunction

   assign beat = in_valid & (state_q == ST_ACC);

   // A clr beat starts a fresh packet, so the old contents are dropped before the adder
   always_comb begin
      add_a      = clr ? '0 : acc_q;
      carry_base = clr ? 1'b0 : carry_q;
      ovf_base   = clr ? 1'b0 : ovf_q;
      cnt_base   = clr ? '0 : cnt_q;
   end

   // Slice chain, cin=0 into the least significant nibble
   always_comb begin
      add_sum  = '0;
      add_c    = '0;
      slice    = '0;
      add_c[0] = 1'b0;
      for (int i = 0; i < int'(NSLICE); i++) begin
         slice            = cla4(add_a[i*4 +: 4], in_data[i*4 +: 4], add_c[i]);
         add_sum[i*4 +: 4] = slice[3:0];
         add_c[i+1]       = slice[4];
      end
   end

   // Next-state and register update logic
   always_comb begin
      state_nxt = state_q;
      acc_nxt   = acc_q;
      carry_nxt = carry_q;
      ovf_nxt   = ovf_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         ST_ACC: begin
            if (beat) begin
               acc_nxt   = add_sum;
               carry_nxt = carry_base | add_c[NSLICE];
               ovf_nxt   = ovf_base | ((add_a[MSB] == in_data[MSB]) & (add_sum[MSB] != add_a[MSB]));
               cnt_nxt   = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
               if (in_last) begin
                  state_nxt = ST_HOLD;
               end
            end else if (clr) begin
               acc_nxt   = '0;
               carry_nxt = 1'b0;
               ovf_nxt   = 1'b0;
               cnt_nxt   = '0;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_nxt = ST_ACC;
               acc_nxt   = '0;
               carry_nxt = 1'b0;
               ovf_nxt   = 1'b0;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_ACC;
         end
      endcase
   end

   // State and datapath registers; handshake flags are decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACC;
         acc_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         rdy_q   <= 1'b1;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         acc_q   <= acc_nxt;
         carry_q <= carry_nxt;
         ovf_q   <= ovf_nxt;
         cnt_q   <= cnt_nxt;
         rdy_q   <= (state_nxt == ST_ACC);
         vld_q   <= (state_nxt == ST_HOLD);
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = vld_q;
   assign out_sum   = acc_q;
   assign out_carry = carry_q;
   assign out_ovf   = ovf_q;
   assign out_count = cnt_q;

endmodule
